// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP ALU byte-serial sequencer.
//   state_t  : FSM state codes, also driven out on the 4-bit state port
//   OP_*     : core opcodes
//   ERR_BYTE : value shown on the output bus while in ERR
package fp_alu_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LOAD_A = 4'd1,
      ST_LOAD_B = 4'd2,
      ST_EXEC   = 4'd3,
      ST_WAIT   = 4'd4,
      ST_UNLOAD = 4'd5,
      ST_DONE   = 4'd6,
      ST_ERR    = 4'd7
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [7:0] ERR_BYTE = 8'hEE;

endpackage

// File: rtl/fp_alu_byte_shreg.sv
// 32-bit byte shift register with a 2-bit byte counter.
//   clr      : zero data and counter (highest priority after reset)
//   load     : parallel load of load_val, counter to 0
//   shift    : q <= {q[23:0], din}
//   adv      : counter +1 (wraps 3->0); independent of shift so the
//              result register can count the final ack without shifting
//   q, cnt   : register contents and byte counter
module fp_alu_byte_shreg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        load,
   input  logic        shift,
   input  logic        adv,
   input  logic [7:0]  din,
   input  logic [31:0] load_val,
   output logic [31:0] q,
   output logic [1:0]  cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         cnt <= '0;
      end else if (clr) begin
         q   <= '0;
         cnt <= '0;
      end else if (load) begin
         q   <= load_val;
         cnt <= '0;
      end else begin
         if (shift) q   <= {q[23:0], din};
         if (adv)   cnt <= cnt + 2'd1;
      end
   end

endmodule

// File: rtl/fp_alu_seq_ctrl.sv
// Byte-serial sequencer between the 8-bit pad bus and the 32-bit FP ALU core.
// Collects A then B (4 bytes each, MSB first), pulses core_go, waits for
// core_valid (with timeout), then hands the result back one byte per ack.
//   in/in_vld      : operand bytes, or read acks while unloading
//   opcode/start   : transaction launch (accepted in IDLE, DONE, ERR)
//   out/done/state : result byte (0xEE in ERR), done flag, FSM code
//   core_*         : operand/opcode/launch to the core, result back
module fp_alu_seq_ctrl
   import fp_alu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 256,
   parameter int TO_W        = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in,
   input  logic        in_vld,
   input  logic [1:0]  opcode,
   input  logic        start,
   output logic [7:0]  out,
   output logic        done,
   output logic [3:0]  state,
   output logic [31:0] core_a,
   output logic [31:0] core_b,
   output logic [1:0]  core_op,
   output logic        core_go,
   input  logic        core_valid,
   input  logic [31:0] core_res
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t          state_q, state_d;
   logic [1:0]      op_q;
   logic [TO_W-1:0] to_cnt;
   logic [31:0]     res_q;
   logic [1:0]      a_cnt, b_cnt, res_cnt;

   logic start_txn, a_sh, b_sh, res_ld, res_sh, res_adv, to_clr, to_inc;

   always_comb begin
      state_d   = state_q;
      start_txn = 1'b0;
      a_sh      = 1'b0;
      b_sh      = 1'b0;
      res_ld    = 1'b0;
      res_sh    = 1'b0;
      res_adv   = 1'b0;
      to_clr    = 1'b0;
      to_inc    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            // start wins over a coincident in_vld: the byte is never shifted
            if (start) begin
               start_txn = 1'b1;
               state_d   = ST_LOAD_A;
            end
         end
         ST_LOAD_A: if (in_vld) begin
            a_sh = 1'b1;
            if (a_cnt == 2'd3) state_d = ST_LOAD_B;
         end
         ST_LOAD_B: if (in_vld) begin
            b_sh = 1'b1;
            if (b_cnt == 2'd3) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            to_clr  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // a result arriving on the expiry cycle still takes priority
            if (core_valid) begin
               res_ld  = 1'b1;
               state_d = ST_UNLOAD;
            end else if (to_cnt == TO_LAST) begin
               state_d = ST_ERR;
            end else begin
               to_inc = 1'b1;
            end
         end
         ST_UNLOAD: if (in_vld) begin
            res_adv = 1'b1;
            // last ack leaves byte 0 on top so DONE keeps showing it
            if (res_cnt == 2'd3) state_d = ST_DONE;
            else                 res_sh  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         to_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (start_txn) op_q <= opcode;
         if (to_clr)      to_cnt <= '0;
         else if (to_inc) to_cnt <= to_cnt + 1'b1;
      end
   end

   fp_alu_byte_shreg u_a (
      .clk(clk), .rst_n(rst_n), .clr(start_txn), .load(1'b0),
      .shift(a_sh), .adv(a_sh), .din(in), .load_val(32'h0),
      .q(core_a), .cnt(a_cnt)
   );

   fp_alu_byte_shreg u_b (
      .clk(clk), .rst_n(rst_n), .clr(start_txn), .load(1'b0),
      .shift(b_sh), .adv(b_sh), .din(in), .load_val(32'h0),
      .q(core_b), .cnt(b_cnt)
   );

   fp_alu_byte_shreg u_res (
      .clk(clk), .rst_n(rst_n), .clr(start_txn), .load(res_ld),
      .shift(res_sh), .adv(res_adv), .din(8'h00), .load_val(core_res),
      .q(res_q), .cnt(res_cnt)
   );

   // every source below is a flop, so out carries no input-to-output path
   always_comb begin
      out = 8'h00;
      case (state_q)
         ST_UNLOAD, ST_DONE: out = res_q[31:24];
         ST_ERR:             out = ERR_BYTE;
         default:            out = 8'h00;
      endcase
   end

   assign done    = (state_q == ST_DONE) || (state_q == ST_ERR);
   assign core_go = (state_q == ST_EXEC);
   assign core_op = op_q;
   assign state   = state_q;

endmodule

// File: tb/tb_fp_alu_seq_ctrl.sv
// Self-checking bench for fp_alu_seq_ctrl: directed scenarios plus randomized
// transactions, checked every cycle against a transaction-level model.
module tb_fp_alu_seq_ctrl;

   localparam int TO = 256;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  in_b = '0;
   logic        in_vld = 1'b0, start = 1'b0, core_valid = 1'b0;
   logic [1:0]  opcode = '0;
   logic [31:0] core_res = '0;
   logic [7:0]  out_b;
   logic        done, core_go;
   logic [3:0]  state;
   logic [31:0] core_a, core_b;
   logic [1:0]  core_op;

   int          vecs = 0, errs = 0;
   int          core_dly = 5;
   logic [31:0] core_val = '0;

   fp_alu_seq_ctrl #(.TIMEOUT_CYC(TO), .TO_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .in(in_b), .in_vld(in_vld), .opcode(opcode),
      .start(start), .out(out_b), .done(done), .state(state),
      .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_go(core_go),
      .core_valid(core_valid), .core_res(core_res)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase uses the externally visible state codes; operands are built by
   // plain arithmetic, the result is read back as byte (3 - acks).
   int          m_st, m_n, m_k, m_wait;
   logic [31:0] m_a, m_b, m_res;
   logic [1:0]  m_op;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = 0; m_n = 0; m_k = 0; m_wait = 0;
         m_a = '0; m_b = '0; m_res = '0; m_op = '0;
      end else begin
         case (m_st)
            0, 6, 7: if (start) begin
               m_op = opcode; m_a = '0; m_b = '0; m_n = 0; m_st = 1;
            end
            1: if (in_vld) begin
               m_a = (m_a << 8) | {24'h0, in_b}; m_n++;
               if (m_n == 4) begin m_n = 0; m_st = 2; end
            end
            2: if (in_vld) begin
               m_b = (m_b << 8) | {24'h0, in_b}; m_n++;
               if (m_n == 4) begin m_n = 0; m_st = 3; end
            end
            3: begin m_wait = 0; m_st = 4; end
            4: begin
               if (core_valid) begin m_res = core_res; m_k = 0; m_st = 5; end
               else if (m_wait == TO - 1) m_st = 7;
               else m_wait++;
            end
            5: if (in_vld) begin
               m_k++;
               if (m_k == 4) m_st = 6;
            end
            default: m_st = 0;
         endcase
      end
   end

   function automatic logic [7:0] exp_out();
      case (m_st)
         5:       return 8'(m_res >> (8 * (3 - m_k)));
         6:       return m_res[7:0];
         7:       return 8'hEE;
         default: return 8'h00;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("state",   32'(state),   32'(m_st));
         chk("out",     32'(out_b),   32'(exp_out()));
         chk("done",    32'(done),    32'(m_st == 6 || m_st == 7));
         chk("core_go", 32'(core_go), 32'(m_st == 3));
         chk("core_a",  core_a,       m_a);
         chk("core_b",  core_b,       m_b);
         chk("core_op", 32'(core_op), 32'(m_op));
      end
   end

   // ---------------- core model ----------------
   initial forever begin
      @(negedge clk);
      if (core_go === 1'b1 && core_dly >= 1) begin
         repeat (core_dly) @(negedge clk);
         core_valid = 1'b1; core_res = core_val;
         @(negedge clk);
         core_valid = 1'b0; core_res = $urandom;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] b, input int gap);
      in_b = b; in_vld = 1'b1;
      @(negedge clk);
      in_vld = 1'b0; in_b = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   task automatic kick(input logic [1:0] op);
      opcode = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0; opcode = 2'($urandom);
   endtask

   task automatic wait_st(input logic [3:0] s, input int budget);
      int i = 0;
      while (state !== s && i < budget) begin @(negedge clk); i++; end
      chk("wait_state", 32'(state), 32'(s));
   endtask

   task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int dly, input logic [31:0] res, input bit stray);
      core_dly = dly; core_val = res;
      kick(op);
      for (int i = 0; i < 4; i++) send(a[8*(3-i) +: 8], int'($urandom_range(0, 2)));
      if (stray) kick(2'($urandom));
      for (int i = 0; i < 4; i++) send(b[8*(3-i) +: 8], (i == 3) ? 0 : int'($urandom_range(0, 2)));
      if (dly >= 1 && dly <= TO) begin
         wait_st(4'd5, 300);
         if (stray) kick(2'($urandom));
         for (int i = 0; i < 4; i++) send(8'($urandom), int'($urandom_range(0, 2)));
         chk("txn_done", 32'(state), 32'd6);
      end else begin
         wait_st(4'd7, 300);
      end
   endtask

   logic [7:0] e1 [4] = '{8'h40, 8'h40, 8'h00, 8'h00};

   initial begin
      // reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_out",   32'(out_b), 32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_go",    32'(core_go), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: 1.0 + 2.0, core answers after 5 cycles
      core_dly = 5; core_val = 32'h40400000;
      kick(2'b00);
      send(8'h3F, 0); send(8'h80, 0); send(8'h00, 0); send(8'h00, 0);
      send(8'h40, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
      chk("t1_exec",  32'(state),   32'd3);
      chk("t1_go",    32'(core_go), 32'd1);
      chk("t1_a",     core_a, 32'h3F800000);
      chk("t1_b",     core_b, 32'h40000000);
      wait_st(4'd5, 20);
      for (int i = 0; i < 4; i++) begin
         chk("t1_out", 32'(out_b), 32'(e1[i]));
         send(8'hA5, 0);
      end
      chk("t1_state", 32'(state), 32'd6);
      chk("t1_done",  32'(done),  32'd1);
      chk("t1_hold",  32'(out_b), 32'h00);

      // 2: core never answers -> ERR, then restart clears A
      run_txn(2'b01, 32'h12345678, 32'h9ABCDEF0, -1, 32'h0, 1'b0);
      chk("t2_out",  32'(out_b), 32'hEE);
      chk("t2_done", 32'(done),  32'd1);
      kick(2'b01);
      chk("t2_restart", 32'(state), 32'd1);
      chk("t2_a_clr",   core_a, 32'h0);

      // 3: async reset in LOAD_B after 2 bytes
      for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 0);
      send(8'hAA, 0); send(8'hBB, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t3_state", 32'(state), 32'd0);
      chk("t3_a",     core_a, 32'h0);
      chk("t3_b",     core_b, 32'h0);
      chk("t3_out",   32'(out_b), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_txn(2'b10, 32'hC0DEC0DE, 32'h01020304, 7, 32'hCAFEF00D, 1'b0);

      // 4: stray start in LOAD_A / WAIT, stray byte in WAIT
      core_dly = 10; core_val = 32'h5EED1234;
      kick(2'b10);
      send(8'h11, 0);
      kick(2'b01);
      chk("t4_loada", 32'(state),   32'd1);
      chk("t4_op",    32'(core_op), 32'd2);
      send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      for (int i = 0; i < 4; i++) send(8'(8'h50 + i), 0);
      wait_st(4'd4, 5);
      kick(2'b00);
      send(8'h99, 0);
      chk("t4_wait", 32'(state), 32'd4);
      chk("t4_a",    core_a, 32'h11223344);
      chk("t4_b",    core_b, 32'h50515253);
      wait_st(4'd5, 20);
      for (int i = 0; i < 4; i++) send(8'h00, 0);
      chk("t4_done", 32'(state), 32'd6);

      // 5: start + in_vld together in DONE
      in_b = 8'h55; in_vld = 1'b1; start = 1'b1; opcode = 2'b00;
      @(negedge clk);
      in_vld = 1'b0; start = 1'b0;
      chk("t5_state", 32'(state), 32'd1);
      chk("t5_a",     core_a, 32'h0);
      core_dly = 4; core_val = 32'h0BADBEEF;
      send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
      chk("t5_loadb", 32'(state), 32'd2);
      chk("t5_a4",    core_a, 32'hA1A2A3A4);
      for (int i = 0; i < 4; i++) send(8'(8'hB0 + i), 0);
      wait_st(4'd5, 20);
      for (int i = 0; i < 4; i++) send(8'h00, 1);

      // 6: result on the exact expiry cycle, then back-to-back div
      run_txn(2'b11, 32'h3F800000, 32'h3F800000, TO, 32'h3F800001, 1'b0);
      run_txn(2'b11, 32'h40800000, 32'h40000000, 3, 32'h40000000, 1'b0);
      chk("t6_op", 32'(core_op), 32'd3);

      // randomized transactions
      for (int t = 0; t < 20; t++) begin
         int d;
         d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 30));
         run_txn(2'($urandom), $urandom, $urandom, d, $urandom, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #1000000;
      errs++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
